// File: rtl/ad_preprocess_scheduler.sv
// Frame scheduler sharing one fix-to-float/gain datapath across CH_NUM AD channels.
// Optional WAIT timeout with sticky err: define AD_SCHED_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for an accepted sta
// ISSUE   | pp_sta pulse for the lowest pending channel
// WAIT    | waiting for pp_done of the current channel
// DONE    | done_sig pulse, frame complete
module ad_preprocess_scheduler #(
    parameter int CH_NUM = 4,
    parameter int AD_W   = 19,
    parameter int FW     = 32
`ifdef AD_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sta,
    input  logic [CH_NUM-1:0]      ch_mask,
    input  logic [CH_NUM*AD_W-1:0] ad_mean_bus,
    input  logic [CH_NUM*FW-1:0]   times_bus,
    output logic                   pp_sta,
    output logic [AD_W-1:0]        pp_ad_mean,
    output logic [FW-1:0]          pp_times,
    input  logic [FW-1:0]          pp_result,
    input  logic                   pp_done,
    output logic [CH_NUM*FW-1:0]   result_bus,
    output logic [CH_NUM-1:0]      result_valid,
    output logic                   busy,
    output logic                   done_sig,
    output logic                   overrun,
    output logic                   err
);

    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CH_NUM-1:0]    pend_q, pend_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic [AD_W-1:0]      pp_mean_q, pp_mean_d;
    logic [FW-1:0]        pp_times_q, pp_times_d;
    logic [AD_W-1:0]      mean_q [CH_NUM];
    logic [FW-1:0]        gain_q [CH_NUM];
    logic [CH_NUM*FW-1:0] res_q;
    logic [CH_NUM-1:0]    rv_q;
    logic                 ovr_q;
    logic                 accept, ch_ok, ch_to, ch_end;

    function automatic logic [CW-1:0] lowest(input logic [CH_NUM-1:0] v);
        lowest = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (v[k]) lowest = CW'(k);
        end
    endfunction

    assign accept = sta && (state_q == S_IDLE);
    assign ch_ok  = (state_q == S_WAIT) && pp_done;
    assign ch_end = ch_ok || ch_to;

`ifdef AD_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;

    // Loaded while in ISSUE so WAIT sees exactly TIMEOUT_CYC cycles before giving up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_ISSUE)
                tmo_q <= TW'(TIMEOUT_CYC - 1);
            else if (state_q == S_WAIT && tmo_q != '0)
                tmo_q <= tmo_q - 1'b1;
            if (accept)
                err_q <= 1'b0;
            else if (ch_to)
                err_q <= 1'b1;
        end
    end

    assign ch_to = (state_q == S_WAIT) && !pp_done && (tmo_q == '0);
    assign err   = err_q;
`else
    assign ch_to = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        ch_d       = ch_q;
        pp_mean_d  = pp_mean_q;
        pp_times_d = pp_times_q;
        case (state_q)
            S_IDLE: begin
                if (sta) begin
                    pend_d = ch_mask;
                    if (ch_mask == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ISSUE;
                        ch_d       = lowest(ch_mask);
                        pp_mean_d  = ad_mean_bus[int'(ch_d)*AD_W +: AD_W];
                        pp_times_d = times_bus[int'(ch_d)*FW +: FW];
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (ch_end) begin
                    pend_d = pend_q & ~(CH_NUM'(1) << ch_q);
                    if (pend_d != '0) begin
                        state_d    = S_ISSUE;
                        ch_d       = lowest(pend_d);
                        pp_mean_d  = mean_q[ch_d];
                        pp_times_d = gain_q[ch_d];
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pend_q     <= '0;
            ch_q       <= '0;
            pp_mean_q  <= '0;
            pp_times_q <= '0;
            res_q      <= '0;
            rv_q       <= '0;
            ovr_q      <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) begin
                mean_q[k] <= '0;
                gain_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            ch_q       <= ch_d;
            pp_mean_q  <= pp_mean_d;
            pp_times_q <= pp_times_d;
            if (accept) begin
                rv_q  <= '0;
                ovr_q <= 1'b0;
                for (int k = 0; k < CH_NUM; k++) begin
                    mean_q[k] <= ad_mean_bus[k*AD_W +: AD_W];
                    gain_q[k] <= times_bus[k*FW +: FW];
                end
            end else if (sta) begin
                ovr_q <= 1'b1;
            end
            if (ch_ok) begin
                res_q[int'(ch_q)*FW +: FW] <= pp_result;
                rv_q[ch_q]                 <= 1'b1;
            end
        end
    end

    assign pp_sta       = (state_q == S_ISSUE);
    assign done_sig     = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE) || accept;
    assign pp_ad_mean   = pp_mean_q;
    assign pp_times     = pp_times_q;
    assign result_bus   = res_q;
    assign result_valid = rv_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_ad_preprocess_scheduler.sv
// Directed bench for ad_preprocess_scheduler with a fixed-latency stub datapath.
// Build with AD_SCHED_TIMEOUT_EN to exercise the channel timeout path.
module tb_ad_preprocess_scheduler;

    localparam int CH_NUM = 4;
    localparam int AD_W   = 19;
    localparam int FW     = 32;
    localparam int LAT    = 10;
    localparam logic [31:0] G2 = 32'h4000_0000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   sta = 1'b0;
    logic [CH_NUM-1:0]      ch_mask = '0;
    logic [CH_NUM*AD_W-1:0] ad_mean_bus = '0;
    logic [CH_NUM*FW-1:0]   times_bus = '0;
    logic                   pp_sta;
    logic [AD_W-1:0]        pp_ad_mean;
    logic [FW-1:0]          pp_times;
    logic [FW-1:0]          pp_result = '0;
    logic                   pp_done = 1'b0;
    logic [CH_NUM*FW-1:0]   result_bus;
    logic [CH_NUM-1:0]      result_valid;
    logic                   busy, done_sig, overrun, err;

    ad_preprocess_scheduler dut (
        .clk(clk), .rst(rst), .sta(sta), .ch_mask(ch_mask),
        .ad_mean_bus(ad_mean_bus), .times_bus(times_bus),
        .pp_sta(pp_sta), .pp_ad_mean(pp_ad_mean), .pp_times(pp_times),
        .pp_result(pp_result), .pp_done(pp_done),
        .result_bus(result_bus), .result_valid(result_valid),
        .busy(busy), .done_sig(done_sig), .overrun(overrun), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub datapath: pp_done LAT cycles after pp_sta, silent for drop_mean.
    int             cnt = 0;
    logic [AD_W-1:0] hold_mean = '0;
    logic [FW-1:0]   hold_times = '0;
    logic [AD_W-1:0] drop_mean = '1;

    function automatic logic [FW-1:0] stub_res(input logic [AD_W-1:0] m, input logic [FW-1:0] t);
        case (m)
            19'd100: stub_res = 32'h4348_0000;
            19'd200: stub_res = 32'h43C8_0000;
            19'd300: stub_res = 32'h4416_0000;
            19'd400: stub_res = 32'h4448_0000;
            default: stub_res = {t[12:0], m};
        endcase
    endfunction

    always @(posedge clk) begin
        pp_done <= 1'b0;
        if (pp_sta) begin
            cnt        <= LAT - 1;
            hold_mean  <= pp_ad_mean;
            hold_times <= pp_times;
        end else if (cnt == 1) begin
            cnt <= 0;
            if (hold_mean != drop_mean) begin
                pp_done   <= 1'b1;
                pp_result <= stub_res(hold_mean, hold_times);
            end
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end
    end

    // Monitor, sampled on the falling edge; cycles are relative to the sta cycle c0.
    int c0 = 0;
    int sta_log[$];
    logic [AD_W-1:0] mean_log[$];
    int done_log[$];
    int busy_first = 0, busy_last = 0, busy_n = 0;
    int late_done = 0;
    bit watch_late = 1'b0;

    always @(negedge clk) begin
        if (pp_sta) begin
            sta_log.push_back(cyc - c0);
            mean_log.push_back(pp_ad_mean);
        end
        if (done_sig) done_log.push_back(cyc - c0);
        if (busy) begin
            if (busy_n == 0) busy_first = cyc - c0;
            busy_last = cyc - c0;
            busy_n++;
        end
        if (watch_late && pp_done) late_done++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] res(input int k);
        res = result_bus[k*FW +: FW];
    endfunction

    task automatic run_frame(input logic [3:0] mask, input logic [AD_W-1:0] m0, m1, m2, m3,
                             input logic [31:0] g);
        tick();
        sta_log.delete();
        mean_log.delete();
        done_log.delete();
        busy_n      = 0;
        ch_mask     = mask;
        ad_mean_bus = {m3, m2, m1, m0};
        times_bus   = {4{g}};
        sta         = 1'b1;
        c0          = cyc;
        tick();
        sta = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_log.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_log.size() == 0) chk("done_timeout", 0, 1);
        tick();
        tick();
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_ctrl", {pp_sta, busy, done_sig, overrun, err, result_valid}, 0);
        chk("rst_pp", {pp_ad_mean, pp_times}, 0);
        chk("rst_res", result_bus, 0);
        rst = 1'b1;
        repeat (2) tick();

        // 1: full mask, latency 10
        run_frame(4'hF, 19'd11, 19'd22, 19'd33, 19'd44, G2);
        wait_done(200);
        chk("t1_nsta", sta_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_sta%0d", i), sta_log[i], 1 + 11 * i);
            chk($sformatf("t1_mean%0d", i), mean_log[i], 11 * (i + 1));
            chk($sformatf("t1_res%0d", i), res(i), 11 * (i + 1));
        end
        chk("t1_ndone", done_log.size(), 1);
        chk("t1_done", done_log[0], 45);
        chk("t1_busy", {busy_first[7:0], busy_last[7:0], busy_n[7:0]}, {8'd0, 8'd45, 8'd46});
        chk("t1_rv", result_valid, 4'hF);
        chk("t1_flags", {overrun, err, busy}, 0);

        // 2: partial mask, real float gains
        run_frame(4'b0101, 19'd100, 19'd200, 19'd300, 19'd400, G2);
        chk("t2_times", pp_times, G2);
        wait_done(200);
        chk("t2_nsta", sta_log.size(), 2);
        chk("t2_mean0", mean_log[0], 100);
        chk("t2_mean1", mean_log[1], 300);
        chk("t2_res0", res(0), 32'h4348_0000);
        chk("t2_res1", res(1), 22);
        chk("t2_res2", res(2), 32'h4416_0000);
        chk("t2_res3", res(3), 44);
        chk("t2_rv", result_valid, 4'b0101);

        // 3: empty mask
        run_frame(4'h0, 19'd1, 19'd2, 19'd3, 19'd4, G2);
        wait_done(20);
        chk("t3_nsta", sta_log.size(), 0);
        chk("t3_done", done_log[0], 1);
        chk("t3_rv", result_valid, 0);
        chk("t3_res0", res(0), 32'h4348_0000);

        // 4: repeated sta mid-frame
        run_frame(4'hF, 19'd5, 19'd6, 19'd7, 19'd8, G2);
        while (cyc < c0 + 5) tick();
        ad_mean_bus = {4{19'd9}};
        times_bus   = '0;
        ch_mask     = 4'h0;
        sta         = 1'b1;
        tick();
        sta = 1'b0;
        chk("t4_ovr_set", overrun, 1);
        wait_done(200);
        chk("t4_nsta", sta_log.size(), 4);
        chk("t4_done", done_log[0], 45);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_res%0d", i), res(i), 5 + i);
        chk("t4_ovr_hold", overrun, 1);

        // 5: dropped pp_done for ch1
        drop_mean = 19'd2;
        run_frame(4'hF, 19'd1, 19'd2, 19'd3, 19'd4, G2);
        chk("t5_ovr_clr", overrun, 0);
`ifdef AD_SCHED_TIMEOUT_EN
        wait_done(400);
        chk("t5_err", err, 1);
        chk("t5_rv", result_valid, 4'b1101);
        chk("t5_sta2", sta_log[2], 77);
        chk("t5_done", done_log[0], 99);
        chk("t5_res1", res(1), 6);
        chk("t5_res2", res(2), 3);
`else
        repeat (150) tick();
        chk("t5_hold_busy", busy, 1);
        chk("t5_err0", err, 0);
        chk("t5_rv", result_valid, 4'b0001);
        chk("t5_ndone", done_log.size(), 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_busy", busy, 0);
`endif
        drop_mean = '1;

        // 6: reset during ch2 WAIT, pp_done arrives after release
        run_frame(4'hF, 19'd1, 19'd2, 19'd3, 19'd4, G2);
        while (cyc < c0 + 26) tick();
        rst = 1'b0;
        #1;
        chk("t6_ctrl", {pp_sta, busy, done_sig, overrun, err, result_valid}, 0);
        chk("t6_res", result_bus, 0);
        chk("t6_pp", {pp_ad_mean, pp_times}, 0);
        tick();
        tick();
        rst = 1'b1;
        watch_late = 1'b1;
        repeat (20) tick();
        watch_late = 1'b0;
        chk("t6_late_seen", late_done, 1);
        chk("t6_nsta", sta_log.size(), 3);
        chk("t6_rv", result_valid, 0);
        chk("t6_res_after", result_bus, 0);
        chk("t6_idle", {busy, done_sig}, 0);
        chk("t6_ndone", done_log.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
